// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc - pipeline hazard controller for the 5-stage MIPS core.
//
// Purpose:
//   Detects load-use and branch operand hazards for the instruction in ID and
//   drives the PC hold and per-stage pipeline-register controls. A small
//   IDLE/STALL sequencer stretches a stall over several cycles, so the load
//   latency (LOAD_LAT) is a parameter. It also flushes IF/ID for jumps and
//   taken branches. Two saturating counters record stall cycles and flush
//   events.
//
// Ports:
//   clk, rst_n            core clock, synchronous active-low reset
//   id_rs/id_rt           source registers of the ID instruction
//   id_use_rs/id_use_rt   ID instruction really reads rs / rt
//   id_branch/id_jump     ID holds a conditional branch / a jump
//   branch_taken          ID branch comparator result
//   ex_rd/ex_regwrite     EX destination and its write enable
//   ex_memread            EX instruction is a load
//   mem_rd/mem_memread    MEM destination and "MEM instruction is a load"
//   *_ctl                 per-stage register control: 00 flush, 01 advance, 10 hold
//   pc_hold               freeze the PC
//   delay                 branch-on-load stall in progress
//   stall_busy            sequencer is in its STALL state
//   stall_cnt/flush_cnt   saturating performance counters

module hazard_ctrl_mc #(
  parameter int REG_W    = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch,
  input  logic             id_jump,
  input  logic             branch_taken,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_regwrite,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_memread,
  output logic [1:0]       if_id_ctl,
  output logic [1:0]       id_ex_ctl,
  output logic [1:0]       ex_mem_ctl,
  output logic [1:0]       mem_wb_ctl,
  output logic             pc_hold,
  output logic             delay,
  output logic             stall_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] CTL_FLUSH = 2'b00;
  localparam logic [1:0] CTL_ADV   = 2'b01;
  localparam logic [1:0] CTL_HOLD  = 2'b10;

  localparam logic [3:0] LAT_N    = 4'(LOAD_LAT);
  localparam logic [3:0] LAT_N_P1 = 4'(LOAD_LAT + 1);

  typedef enum logic {S_IDLE, S_STALL} state_t;

  state_t           r_state;
  logic [2:0]       r_rem;
  logic             r_delay;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic       w_mrs_ex, w_mrt_ex, w_mrs_mem, w_mrt_mem;
  logic       w_match_ex, w_match_mem;
  logic       w_load_use, w_br_load_ex, w_br_alu, w_br_load_mem;
  logic       w_hit;
  logic [3:0] w_need;
  logic       w_need_delay;
  logic       w_flush;

  // Register 0 never carries a real dependency, and an operand the
  // instruction does not read cannot create one.
  assign w_mrs_ex  = id_use_rs && (id_rs == ex_rd)  && (ex_rd != '0)  && ex_regwrite;
  assign w_mrt_ex  = id_use_rt && (id_rt == ex_rd)  && (ex_rd != '0)  && ex_regwrite;
  assign w_mrs_mem = id_use_rs && (id_rs == mem_rd) && (mem_rd != '0) && mem_memread;
  assign w_mrt_mem = id_use_rt && (id_rt == mem_rd) && (mem_rd != '0) && mem_memread;

  assign w_match_ex  = w_mrs_ex  || w_mrt_ex;
  assign w_match_mem = w_mrs_mem || w_mrt_mem;

  assign w_load_use    = !id_branch && ex_memread && w_match_ex;
  assign w_br_load_ex  =  id_branch && ex_memread && w_match_ex;
  assign w_br_alu      =  id_branch && !ex_memread && w_match_ex;
  assign w_br_load_mem =  id_branch && w_match_mem;

  assign w_hit = w_load_use || w_br_load_ex || w_br_alu || w_br_load_mem;

  // Stall length for the first matching hazard kind. A branch needs its
  // operands in ID, one stage earlier than an ALU consumer, hence the +1
  // when the load is still in EX.
  always_comb begin
    w_need       = 4'd0;
    w_need_delay = 1'b0;
    if (w_load_use) begin
      w_need = LAT_N;
    end else if (w_br_load_ex) begin
      w_need       = LAT_N_P1;
      w_need_delay = 1'b1;
    end else if (w_br_alu) begin
      w_need = 4'd1;
    end else if (w_br_load_mem) begin
      w_need       = LAT_N;
      w_need_delay = 1'b1;
    end
  end

  // Output decode. Reset overrides everything so a stall in flight is
  // dropped the moment rst_n falls.
  always_comb begin
    if_id_ctl  = CTL_ADV;
    id_ex_ctl  = CTL_ADV;
    ex_mem_ctl = CTL_ADV;
    mem_wb_ctl = CTL_ADV;
    pc_hold    = 1'b0;
    delay      = 1'b0;
    w_flush    = 1'b0;
    if (rst_n) begin
      if (r_state == S_STALL) begin
        if_id_ctl = CTL_HOLD;
        id_ex_ctl = CTL_FLUSH;
        pc_hold   = 1'b1;
        delay     = r_delay;
      end else if (w_hit) begin
        if_id_ctl = CTL_HOLD;
        id_ex_ctl = CTL_FLUSH;
        pc_hold   = 1'b1;
        delay     = w_need_delay;
      end else if (id_jump || (id_branch && branch_taken)) begin
        if_id_ctl = CTL_FLUSH;
        w_flush   = 1'b1;
      end
    end
  end

  assign stall_busy = rst_n && (r_state == S_STALL);
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;

  // The first stall cycle is issued from IDLE, so STALL covers the
  // remaining N-1 cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_rem       <= 3'd0;
      r_delay     <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hit && (w_need > 4'd1)) begin
            r_state <= S_STALL;
            r_rem   <= 3'(w_need - 4'd1);
            r_delay <= w_need_delay;
          end
        end
        S_STALL: begin
          r_rem <= r_rem - 3'd1;
          if (r_rem == 3'd1) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      if (pc_hold && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

endmodule

// File: doc/hazard_ctrl_mc.md
Name: hazard_ctrl_mc

Overview:
- Parametrised successor to the pipeline hazard unit of the 5-stage MIPS core; generates PC hold and per-stage-register control (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Adds a multi-cycle stall sequencer, so load latency (LOAD_LAT) is configurable and a branch-after-load is stalled for the correct number of cycles without an external delay loop.
- Suppresses false hazards on register 0 and on unused source operands; adds saturating stall/flush performance counters.

Parameters:
- REG_W, 5, register-address width
- LOAD_LAT, 1, cycles a load result lags an ALU result (1..7)
- CNT_W, 32, performance-counter width

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- id_rs  in  REG_W  rs of instruction in ID
- id_rt  in  REG_W  rt of instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_branch  in  1  ID holds a conditional branch (resolved in ID)
- id_jump  in  1  ID holds j/jal/jr/jalr
- branch_taken  in  1  ID branch comparator result
- ex_rd  in  REG_W  destination of instruction in EX
- ex_regwrite  in  1  EX instruction writes ex_rd
- ex_memread  in  1  EX instruction is a load
- mem_rd  in  REG_W  destination of instruction in MEM
- mem_memread  in  1  MEM instruction is a load
- if_id_ctl  out  2  00 flush, 01 advance, 10 hold
- id_ex_ctl  out  2  same encoding
- ex_mem_ctl  out  2  same encoding
- mem_wb_ctl  out  2  same encoding
- pc_hold  out  1  freeze PC
- delay  out  1  branch-on-load stall in progress
- stall_busy  out  1  sequencer in STALL state
- stall_cnt  out  CNT_W  total stall cycles, saturating
- flush_cnt  out  CNT_W  total control-flow flush events, saturating

Behaviour:
- Match terms: mX_ex = id_use_X && id_X == ex_rd && ex_rd != 0 && ex_regwrite; mX_mem = id_use_X && id_X == mem_rd && mem_rd != 0 && mem_memread; X in {rs, rt}.
- Required stall count N, evaluated in IDLE, first match wins:
  - load_use: !id_branch && ex_memread && (mrs_ex || mrt_ex) -> N = LOAD_LAT.
  - br_load_ex: id_branch && ex_memread && match_ex -> N = LOAD_LAT+1.
  - br_alu: id_branch && !ex_memread && match_ex -> N = 1.
  - br_load_mem: id_branch && match_mem -> N = LOAD_LAT.
- Stall outputs:
  - if_id_ctl = 10, id_ex_ctl = 00, ex_mem_ctl = mem_wb_ctl = 01, pc_hold = 1.
  - delay = 1 for the br_load_* kinds.
- FSM states IDLE and STALL, with down-counter rem (3 bits).
  - IDLE with hazard: drive the stall outputs this cycle. If N > 1, go to STALL with rem = N-1; otherwise stay in IDLE.
  - STALL: drive the stall outputs (delay latched from the entry kind) and ignore all match, jump and branch inputs. Decrement rem; on rem == 1, go to IDLE. Detection is re-evaluated the following cycle.
- IDLE with no hazard, lower priority:
  - id_jump -> if_id_ctl = 00, others 01, pc_hold = 0.
  - Else id_branch && branch_taken -> same flush pattern.
  - Else all 01, pc_hold = 0, delay = 0.
- A jr dependent on a load takes the load_use stall first; the jump flush follows.
- stall_busy = (state == STALL).
- Counters:
  - stall_cnt increments on every cycle pc_hold = 1.
  - flush_cnt increments on each cycle a jump/taken-branch flush pattern is driven.
  - Both saturate at all-ones.
- Reset:
  - rst_n low at a clk edge sets state = IDLE, rem = 0, counters = 0.
  - While rst_n is low, outputs are forced to all ctl 01, pc_hold 0, delay 0, stall_busy 0. This holds even mid-stall.
- All ctl outputs are combinational from state and inputs; no output glitch requirement beyond a settled value at the clock edge.

Test Plan:
- LOAD_LAT=1, lw $8 in EX, add using $8 in ID -> one cycle with if_id_ctl=10, id_ex_ctl=00, pc_hold=1, delay=0; next cycle all 01; stall_cnt=1.
- LOAD_LAT=3, same load-use -> exactly 3 stall cycles, stall_busy high for cycles 2-3; inputs toggled during STALL have no effect; stall_cnt=3.
- LOAD_LAT=1, lw $9 in EX, beq on $9 in ID -> 2 stall cycles with delay=1 in both; then, with branch_taken=1 -> one cycle if_id_ctl=00, flush_cnt=1.
- Load to $0 in EX with beq $0,$0, and rt unused with a matching id_rt -> no stall; taken branch flushes immediately.
- jal in ID with no hazard -> if_id_ctl=00, pc_hold=0; jr $10 after lw $10 -> load_use stall first, then the flush cycle.
- rst_n low in the second cycle of a LOAD_LAT=3 stall -> outputs normal immediately; after release: state IDLE, stall_cnt=0, flush_cnt=0.
